// File: rtl/trace_width_ctrl.sv
// rtl/trace_width_ctrl.sv - trace bus width hunt/lock controller for the frame builder
// Optional lock/loss statistics counters are built only when TRACE_WIDTH_STATS_EN is defined.
module trace_width_ctrl #(
  parameter int HUNT_CYCLES   = 4096,
  parameter int LOSS_CYCLES   = 65536,
  parameter int SYNC_CONFIRM  = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        rst,
  input  logic        traceClkin,
  input  logic        forceEn,
  input  logic [1:0]  forceWidth,
  input  logic [15:0] SyncCount,
  output logic [1:0]  width,
  output logic        locked,
  output logic [1:0]  state,
  output logic [7:0]  lockCount,
  output logic [7:0]  lossCount
);

  localparam int MAX_HL  = (HUNT_CYCLES > LOSS_CYCLES) ? HUNT_CYCLES : LOSS_CYCLES;
  localparam int MAX_CYC = (MAX_HL > SETTLE_CYCLES) ? MAX_HL : SETTLE_CYCLES;
  localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_HUNT    = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t         fsm;
  logic [TW-1:0]  timer;
  logic [3:0]     confirm_cnt;
  logic [15:0]    prev_sync;
  logic           sync_ev;
  logic [4:0]     confirm_nxt;
  logic           lock_entry;
  logic           loss_exit;
  logic           settle_done;
  logic           hunt_expired;

  assign state        = fsm;
  assign sync_ev      = (SyncCount != prev_sync);
  assign confirm_nxt  = {1'b0, confirm_cnt} + 5'd1;
  assign settle_done  = (timer == TW'(SETTLE_CYCLES - 1));
  assign hunt_expired = (timer == TW'(HUNT_CYCLES - 1));

  // Shared with the statistics counters so they count exactly the FSM's transitions.
  assign lock_entry = !forceEn && sync_ev &&
                      (((fsm == ST_HUNT) && (SYNC_CONFIRM <= 1)) ||
                       ((fsm == ST_CONFIRM) && (confirm_nxt >= 5'(SYNC_CONFIRM))));
  assign loss_exit  = !forceEn && !sync_ev && (fsm == ST_LOCKED) &&
                      (timer == TW'(LOSS_CYCLES - 1));

  function automatic logic [1:0] next_width(input logic [1:0] w);
    case (w)
      2'b11:   next_width = 2'b10;
      2'b10:   next_width = 2'b01;
      default: next_width = 2'b11;
    endcase
  endfunction

  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      fsm         <= ST_SETTLE;
      width       <= 2'b11;
      locked      <= 1'b0;
      timer       <= '0;
      confirm_cnt <= '0;
      prev_sync   <= '0;
    end else begin
      prev_sync <= SyncCount;
      if (forceEn) begin
        width       <= (forceWidth == 2'b00) ? 2'b01 : forceWidth;
        fsm         <= ST_SETTLE;
        timer       <= '0;
        confirm_cnt <= '0;
        locked      <= 1'b0;
      end else if (lock_entry) begin
        fsm         <= ST_LOCKED;
        locked      <= 1'b1;
        timer       <= '0;
        confirm_cnt <= '0;
      end else begin
        case (fsm)
          ST_SETTLE: begin
            // Sync events are ignored here while the builder flushes the old width.
            if (settle_done) begin
              fsm   <= ST_HUNT;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_HUNT, ST_CONFIRM: begin
            if (sync_ev) begin
              fsm         <= ST_CONFIRM;
              confirm_cnt <= confirm_nxt[3:0];
              timer       <= '0;
            end else if (hunt_expired) begin
              fsm         <= ST_SETTLE;
              width       <= next_width(width);
              confirm_cnt <= '0;
              timer       <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            if (sync_ev) begin
              timer <= '0;
            end else if (loss_exit) begin
              fsm    <= ST_HUNT;
              locked <= 1'b0;
              timer  <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        endcase
      end
    end
  end

`ifdef TRACE_WIDTH_STATS_EN
  logic [7:0] lock_cnt;
  logic [7:0] loss_cnt;

  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      loss_cnt <= '0;
    end else begin
      if (lock_entry && (lock_cnt != 8'hFF)) lock_cnt <= lock_cnt + 8'd1;
      if (loss_exit && (loss_cnt != 8'hFF))  loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign lockCount = lock_cnt;
  assign lossCount = loss_cnt;
`else
  assign lockCount = 8'd0;
  assign lossCount = 8'd0;
`endif

endmodule

// File: tb/tb_trace_width_ctrl.sv
// tb/tb_trace_width_ctrl.sv - directed table-driven bench for trace_width_ctrl
module tb_trace_width_ctrl;

  localparam int HUNT_CYCLES   = 64;
  localparam int LOSS_CYCLES   = 256;
  localparam int SYNC_CONFIRM  = 2;
  localparam int SETTLE_CYCLES = 16;
`ifdef TRACE_WIDTH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        rst;
  logic        traceClkin;
  logic        forceEn;
  logic [1:0]  forceWidth;
  logic [15:0] SyncCount;
  logic [1:0]  width;
  logic        locked;
  logic [1:0]  state;
  logic [7:0]  lockCount;
  logic [7:0]  lossCount;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          r;
    int          c;
    bit          fe;
    logic [1:0]  fw;
    logic [15:0] sync;
    logic [1:0]  w;
    logic [1:0]  st;
    bit          lk;
    logic [7:0]  lkc;
    logic [7:0]  lsc;
  } vec_t;

  vec_t vecs[$];

  trace_width_ctrl #(
    .HUNT_CYCLES  (HUNT_CYCLES),
    .LOSS_CYCLES  (LOSS_CYCLES),
    .SYNC_CONFIRM (SYNC_CONFIRM),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .rst       (rst),
    .traceClkin(traceClkin),
    .forceEn   (forceEn),
    .forceWidth(forceWidth),
    .SyncCount (SyncCount),
    .width     (width),
    .locked    (locked),
    .state     (state),
    .lockCount (lockCount),
    .lossCount (lossCount)
  );

  initial traceClkin = 1'b0;
  always #5 traceClkin = ~traceClkin;

  function automatic vec_t v(input bit r, input int c, input bit fe, input logic [1:0] fw,
                             input logic [15:0] s, input logic [1:0] w, input logic [1:0] st,
                             input bit lk, input int lkc, input int lsc);
    vec_t x;
    x.r = r; x.c = c; x.fe = fe; x.fw = fw; x.sync = s;
    x.w = w; x.st = st; x.lk = lk;
    x.lkc = STATS ? 8'(lkc) : 8'd0;
    x.lsc = STATS ? 8'(lsc) : 8'd0;
    return x;
  endfunction

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge traceClkin);
      cyc++;
    end
    if (n > 0) #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    forceEn    = 1'b0;
    forceWidth = 2'b00;
    SyncCount  = 16'h0000;
    @(posedge traceClkin);
    @(posedge traceClkin);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check(input string name, input logic [1:0] ew, input logic [1:0] es,
                       input bit el, input logic [7:0] elk, input logic [7:0] els);
    checks++;
    if (width !== ew || state !== es || locked !== el || lockCount !== elk || lossCount !== els) begin
      failures++;
      $display("FAIL %s cyc=%0d got w=%b st=%0d lk=%b lkc=%0d lsc=%0d expected w=%b st=%0d lk=%b lkc=%0d lsc=%0d",
               name, cyc, width, state, locked, lockCount, lossCount, ew, es, el, elk, els);
    end
  endtask

  initial begin
    rst        = 1'b1;
    forceEn    = 1'b0;
    forceWidth = 2'b00;
    SyncCount  = 16'h0000;

    // Free hunt with no sync activity: 11 -> 10 -> 01 -> 11, 80 cycles apart.
    vecs.push_back(v(1,   0, 0, 2'b00, 16'h0000, 2'b11, 2'd0, 0, 0, 0));
    vecs.push_back(v(0,  15, 0, 2'b00, 16'h0000, 2'b11, 2'd0, 0, 0, 0));
    vecs.push_back(v(0,  16, 0, 2'b00, 16'h0000, 2'b11, 2'd1, 0, 0, 0));
    vecs.push_back(v(0,  79, 0, 2'b00, 16'h0000, 2'b11, 2'd1, 0, 0, 0));
    vecs.push_back(v(0,  80, 0, 2'b00, 16'h0000, 2'b10, 2'd0, 0, 0, 0));
    vecs.push_back(v(0,  96, 0, 2'b00, 16'h0000, 2'b10, 2'd1, 0, 0, 0));
    vecs.push_back(v(0, 159, 0, 2'b00, 16'h0000, 2'b10, 2'd1, 0, 0, 0));
    vecs.push_back(v(0, 160, 0, 2'b00, 16'h0000, 2'b01, 2'd0, 0, 0, 0));
    vecs.push_back(v(0, 176, 0, 2'b00, 16'h0000, 2'b01, 2'd1, 0, 0, 0));
    vecs.push_back(v(0, 240, 0, 2'b00, 16'h0000, 2'b11, 2'd0, 0, 0, 0));
    // Confirm, lock, loss, settle masking, wrap event, confirm timeout.
    vecs.push_back(v(1,   0, 0, 2'b00, 16'h0000, 2'b11, 2'd0, 0, 0, 0));
    vecs.push_back(v(0,  20, 0, 2'b00, 16'h0001, 2'b11, 2'd1, 0, 0, 0));
    vecs.push_back(v(0,  21, 0, 2'b00, 16'h0001, 2'b11, 2'd2, 0, 0, 0));
    vecs.push_back(v(0,  50, 0, 2'b00, 16'h0002, 2'b11, 2'd2, 0, 0, 0));
    vecs.push_back(v(0,  51, 0, 2'b00, 16'h0002, 2'b11, 2'd3, 1, 1, 0));
    vecs.push_back(v(0, 306, 0, 2'b00, 16'h0002, 2'b11, 2'd3, 1, 1, 0));
    vecs.push_back(v(0, 307, 0, 2'b00, 16'h0002, 2'b11, 2'd1, 0, 1, 1));
    vecs.push_back(v(0, 370, 0, 2'b00, 16'h0002, 2'b11, 2'd1, 0, 1, 1));
    vecs.push_back(v(0, 371, 0, 2'b00, 16'h0002, 2'b10, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 374, 0, 2'b00, 16'h0003, 2'b10, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 381, 0, 2'b00, 16'hFFFF, 2'b10, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 386, 0, 2'b00, 16'hFFFF, 2'b10, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 387, 0, 2'b00, 16'hFFFF, 2'b10, 2'd1, 0, 1, 1));
    vecs.push_back(v(0, 390, 0, 2'b00, 16'h0000, 2'b10, 2'd1, 0, 1, 1));
    vecs.push_back(v(0, 391, 0, 2'b00, 16'h0000, 2'b10, 2'd2, 0, 1, 1));
    vecs.push_back(v(0, 454, 0, 2'b00, 16'h0000, 2'b10, 2'd2, 0, 1, 1));
    vecs.push_back(v(0, 455, 0, 2'b00, 16'h0000, 2'b01, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 471, 0, 2'b00, 16'h0000, 2'b01, 2'd1, 0, 1, 1));
    vecs.push_back(v(0, 480, 0, 2'b00, 16'h0001, 2'b01, 2'd1, 0, 1, 1));
    // Force from mid-CONFIRM, then release and re-hunt on the forced width.
    vecs.push_back(v(0, 481, 1, 2'b10, 16'h0001, 2'b01, 2'd2, 0, 1, 1));
    vecs.push_back(v(0, 482, 1, 2'b00, 16'h0001, 2'b10, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 483, 1, 2'b00, 16'h0001, 2'b01, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 500, 1, 2'b00, 16'h0002, 2'b01, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 600, 0, 2'b00, 16'h0002, 2'b01, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 615, 0, 2'b00, 16'h0002, 2'b01, 2'd0, 0, 1, 1));
    vecs.push_back(v(0, 616, 0, 2'b00, 16'h0002, 2'b01, 2'd1, 0, 1, 1));
    vecs.push_back(v(0, 620, 0, 2'b00, 16'h0003, 2'b01, 2'd1, 0, 1, 1));
    vecs.push_back(v(0, 621, 0, 2'b00, 16'h0003, 2'b01, 2'd2, 0, 1, 1));
    vecs.push_back(v(0, 622, 0, 2'b00, 16'h0004, 2'b01, 2'd2, 0, 1, 1));
    vecs.push_back(v(0, 623, 0, 2'b00, 16'h0004, 2'b01, 2'd3, 1, 2, 1));
    vecs.push_back(v(0, 878, 0, 2'b00, 16'h0004, 2'b01, 2'd3, 1, 2, 1));
    vecs.push_back(v(0, 879, 0, 2'b00, 16'h0004, 2'b01, 2'd1, 0, 2, 2));
    vecs.push_back(v(0, 880, 0, 2'b00, 16'h0005, 2'b01, 2'd1, 0, 2, 2));
    vecs.push_back(v(0, 881, 0, 2'b00, 16'h0006, 2'b01, 2'd2, 0, 2, 2));
    vecs.push_back(v(0, 882, 0, 2'b00, 16'h0006, 2'b01, 2'd3, 1, 3, 2));

    foreach (vecs[i]) begin
      if (vecs[i].r) do_reset();
      else adv(vecs[i].c - cyc);
      check($sformatf("vec%0d", i), vecs[i].w, vecs[i].st, vecs[i].lk, vecs[i].lkc, vecs[i].lsc);
      forceEn    = vecs[i].fe;
      forceWidth = vecs[i].fw;
      SyncCount  = vecs[i].sync;
    end

    // Asynchronous reset while LOCKED: outputs clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 2'b11, 2'd0, 1'b0, 8'd0, 8'd0);
    @(posedge traceClkin);
    #1;
    check("rst_held", 2'b11, 2'd0, 1'b0, 8'd0, 8'd0);
    rst       = 1'b0;
    SyncCount = 16'h0000;
    cyc       = 0;
    adv(16);
    check("post_rst_hunt", 2'b11, 2'd1, 1'b0, 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
